// File: rtl/serial_word_deserializer.sv
// Reassembles framed words from a strobed serial bit stream and presents them
// on a valid/ready interface behind a one-entry holding register.
module serial_word_deserializer #(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_ser_in,
  input  logic                          i_ser_valid,
  input  logic                          i_sync,
  input  logic                          i_clr_err,
  output logic [DATA_WIDTH-1:0]         o_par_out,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic                          o_busy,
  output logic [$clog2(DATA_WIDTH)-1:0] o_bit_cnt,
  output logic                          o_overflow,
  output logic                          o_sync_err
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH - 1);

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  state_t                r_state, w_state_next;
  logic [DATA_WIDTH-1:0] r_sh, w_sh_next;
  logic [DATA_WIDTH-1:0] r_par, w_par_next;
  logic [DATA_WIDTH-1:0] w_shifted, w_first;
  logic [CW-1:0]         r_cnt, w_cnt_next;
  logic                  r_valid, w_valid_next;
  logic                  r_ovf, w_ovf_next;
  logic                  r_serr, w_serr_next;
  logic                  w_done, w_ovf_set, w_serr_set;

  // w_first places a lone bit where a fresh word's first bit must start so that
  // the remaining shifts carry it to its final position.
  generate
    if (MSB_FIRST) begin : g_msb
      assign w_shifted = {r_sh[DATA_WIDTH-2:0], i_ser_in};
      assign w_first   = {{(DATA_WIDTH-1){1'b0}}, i_ser_in};
    end else begin : g_lsb
      assign w_shifted = {i_ser_in, r_sh[DATA_WIDTH-1:1]};
      assign w_first   = {i_ser_in, {(DATA_WIDTH-1){1'b0}}};
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_sh    <= '0;
      r_cnt   <= '0;
      r_par   <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      r_serr  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_sh    <= w_sh_next;
      r_cnt   <= w_cnt_next;
      r_par   <= w_par_next;
      r_valid <= w_valid_next;
      r_ovf   <= w_ovf_next;
      r_serr  <= w_serr_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_sh_next    = r_sh;
    w_cnt_next   = r_cnt;
    w_par_next   = r_par;
    w_valid_next = r_valid;
    w_done       = 1'b0;
    w_ovf_set    = 1'b0;
    w_serr_set   = 1'b0;

    if (i_ser_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (i_sync) begin
            w_state_next = ST_ACTIVE;
            w_sh_next    = w_first;
            w_cnt_next   = CW'(1);
          end
        end
        ST_ACTIVE: begin
          if (i_sync && (r_cnt != '0)) begin
            w_serr_set = 1'b1;
            w_sh_next  = w_first;
            w_cnt_next = CW'(1);
          end else if (r_cnt == LAST_CNT) begin
            w_done     = 1'b1;
            w_sh_next  = w_shifted;
            w_cnt_next = '0;
          end else begin
            w_sh_next  = w_shifted;
            w_cnt_next = r_cnt + 1'b1;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end

    // A completed word only lands if the holding register is empty or draining now.
    if (w_done) begin
      if (!r_valid || i_ready) begin
        w_valid_next = 1'b1;
        w_par_next   = w_shifted;
      end else begin
        w_ovf_set = 1'b1;
      end
    end else if (r_valid && i_ready) begin
      w_valid_next = 1'b0;
    end

    w_ovf_next  = (r_ovf  & ~i_clr_err) | w_ovf_set;
    w_serr_next = (r_serr & ~i_clr_err) | w_serr_set;
  end

  assign o_par_out  = r_par;
  assign o_valid    = r_valid;
  assign o_busy     = (r_state == ST_ACTIVE);
  assign o_bit_cnt  = r_cnt;
  assign o_overflow = r_ovf;
  assign o_sync_err = r_serr;

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Self-checking bench: MSB-first and LSB-first instances share one stimulus
// stream and are compared against a queue-based frame model every cycle.
module tb_serial_word_deserializer;

  localparam int DW = 8;
  localparam int CW = $clog2(DW);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, ser = 1'b0, sv = 1'b0, sync = 1'b0, clr = 1'b0, rdy = 1'b0;
  logic [DW-1:0] par_a, par_b;
  logic [CW-1:0] cnt_a, cnt_b;
  logic val_a, val_b, busy_a, busy_b, ovf_a, ovf_b, se_a, se_b;

  serial_word_deserializer #(.DATA_WIDTH(DW), .MSB_FIRST(1'b1)) u_msb (
    .i_clk(clk), .i_rst(rst), .i_ser_in(ser), .i_ser_valid(sv), .i_sync(sync),
    .i_clr_err(clr), .o_par_out(par_a), .o_valid(val_a), .i_ready(rdy),
    .o_busy(busy_a), .o_bit_cnt(cnt_a), .o_overflow(ovf_a), .o_sync_err(se_a));

  serial_word_deserializer #(.DATA_WIDTH(DW), .MSB_FIRST(1'b0)) u_lsb (
    .i_clk(clk), .i_rst(rst), .i_ser_in(ser), .i_ser_valid(sv), .i_sync(sync),
    .i_clr_err(clr), .o_par_out(par_b), .o_valid(val_b), .i_ready(rdy),
    .o_busy(busy_b), .o_bit_cnt(cnt_b), .o_overflow(ovf_b), .o_sync_err(se_b));

  int total = 0;
  int bad   = 0;

  // Reference model: the bits of the current frame in arrival order.
  bit            m_active = 1'b0;
  bit            m_bits[$];
  bit            m_valid  = 1'b0;
  logic [DW-1:0] m_msb    = '0;
  logic [DW-1:0] m_lsb    = '0;
  bit            m_ovf    = 1'b0;
  bit            m_serr   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit            done     = 1'b0;
    bit            ovf_set  = 1'b0;
    bit            serr_set = 1'b0;
    logic [DW-1:0] wm = '0;
    logic [DW-1:0] wl = '0;
    if (rst) begin
      m_active = 1'b0; m_bits.delete(); m_valid = 1'b0;
      m_msb = '0; m_lsb = '0; m_ovf = 1'b0; m_serr = 1'b0;
    end else begin
      if (sv) begin
        if (sync) begin
          if (m_active && m_bits.size() != 0) serr_set = 1'b1;
          m_bits.delete();
          m_bits.push_back(ser);
          m_active = 1'b1;
        end else if (m_active) begin
          m_bits.push_back(ser);
        end
        if (m_bits.size() == DW) begin
          done = 1'b1;
          for (int i = 0; i < DW; i++) begin
            wm[DW-1-i] = m_bits[i];
            wl[i]      = m_bits[i];
          end
          m_bits.delete();
        end
      end
      if (done) begin
        if (!m_valid || rdy) begin
          m_valid = 1'b1; m_msb = wm; m_lsb = wl;
        end else begin
          ovf_set = 1'b1;
        end
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
      end
      m_ovf  = (m_ovf  && !clr) || ovf_set;
      m_serr = (m_serr && !clr) || serr_set;
    end
  endtask

  task automatic check_all();
    chk("valid_msb", {31'd0, val_a},  {31'd0, m_valid});
    chk("valid_lsb", {31'd0, val_b},  {31'd0, m_valid});
    chk("par_msb",   32'(par_a),      32'(m_msb));
    chk("par_lsb",   32'(par_b),      32'(m_lsb));
    chk("busy",      {31'd0, busy_a}, {31'd0, m_active});
    chk("bit_cnt",   32'(cnt_a),      32'(m_bits.size()));
    chk("overflow",  {31'd0, ovf_a},  {31'd0, m_ovf});
    chk("sync_err",  {31'd0, se_b},   {31'd0, m_serr});
  endtask

  task automatic step(input logic r, input logic b, input logic v, input logic sy,
                      input logic rd, input logic cl);
    rst = r; ser = b; sv = v; sync = sy; rdy = rd; clr = cl;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Sends w MSB first; optional idle strobe cycle between bits.
  task automatic send_word(input logic [7:0] w, input bit sy_first, input logic rd, input bit gaps);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, w[7-i], 1'b1, (i == 0) && sy_first, rd, 1'b0);
      if (gaps && i < 7) step(1'b0, 1'($urandom), 1'b0, 1'b0, rd, 1'b0);
    end
  endtask

  initial begin
    logic [7:0] rw;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("rst_valid", {31'd0, val_a}, 32'd0);
    chk("rst_par",   32'(par_a),     32'd0);
    chk("rst_busy",  {31'd0, busy_a}, 32'd0);

    send_word(8'hA5, 1'b1, 1'b1, 1'b0);
    chk("a5_valid", {31'd0, val_a}, 32'd1);
    chk("a5_par",   32'(par_a),     32'hA5);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("a5_pulse_end", {31'd0, val_a}, 32'd0);

    send_word(8'h3C, 1'b1, 1'b1, 1'b0);
    chk("b2b_first", 32'(par_a), 32'h3C);
    send_word(8'hC3, 1'b0, 1'b1, 1'b0);
    chk("b2b_second", 32'(par_a), 32'hC3);
    chk("b2b_no_ovf", {31'd0, ovf_a}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    send_word(8'h11, 1'b0, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0, 1'b0);
    chk("ovf_hold", 32'(par_a), 32'h11);
    chk("ovf_flag", {31'd0, ovf_a}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ovf_drain", {31'd0, val_a}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("ovf_clear", {31'd0, ovf_a}, 32'd0);

    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'($urandom), 1'b1, 1'b0, 1'b1, 1'b0);
    chk("presync_idle", {31'd0, busy_a}, 32'd0);
    chk("presync_cnt",  32'(cnt_a),      32'd0);
    send_word(8'h5A, 1'b1, 1'b1, 1'b1);
    chk("gap_par", 32'(par_a), 32'h5A);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 3; i++) step(1'b0, 1'($urandom), 1'b1, 1'b0, 1'b1, 1'b0);
    send_word(8'h96, 1'b1, 1'b1, 1'b0);
    chk("resync_err", {31'd0, se_a}, 32'd1);
    chk("resync_par", 32'(par_a),    32'h96);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    send_word(8'h4D, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("midrst_valid", {31'd0, val_a},  32'd0);
    chk("midrst_par",   32'(par_a),      32'd0);
    chk("midrst_busy",  {31'd0, busy_a}, 32'd0);
    chk("midrst_cnt",   32'(cnt_a),      32'd0);
    rw = 8'($urandom);
    send_word(rw, 1'b1, 1'b1, 1'b0);
    chk("postrst_word", 32'(par_a), 32'(rw));

    send_word(8'h80, 1'b1, 1'b1, 1'b0);
    chk("lsb_first_01", 32'(par_b), 32'h01);
    chk("msb_first_80", 32'(par_a), 32'h80);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 199) == 0), 1'($urandom), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 11) == 0), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 15) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_word_deserializer.md
Name: serial_word_deserializer

Overview:
- Downstream neighbour of the 8-bit parallel-load/serial-out shift register.
- Consumes its serial bit stream and a per-bit strobe, and reassembles framed words.
- Presents each word on a valid/ready parallel interface behind a one-entry holding register.
- Flags dropped words (overflow) and mid-word resynchronisation.

Parameters:
- DATA_WIDTH, 8, bits per word; legal values are 2 or more.
- MSB_FIRST, 1, 1 means the first received bit lands in bit DATA_WIDTH-1 (matches the upstream shift register, which emits bit 7 first); 0 means the first received bit lands in bit 0.

Ports:
- i_clk  in  1  clock; all logic is on the rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_ser_in  in  1  serial data bit.
- i_ser_valid  in  1  bit strobe; i_ser_in is sampled only when this is 1.
- i_sync  in  1  frame marker; qualified by i_ser_valid; marks the current bit as bit 0 of a word.
- i_clr_err  in  1  clears o_overflow and o_sync_err.
- o_par_out  out  DATA_WIDTH  assembled word; stable while o_valid=1.
- o_valid  out  1  o_par_out holds an unconsumed word.
- i_ready  in  1  consumer accepts the word on a cycle where o_valid=1 and i_ready=1.
- o_busy  out  1  FSM is in ACTIVE.
- o_bit_cnt  out  $clog2(DATA_WIDTH)  bits collected in the current word.
- o_overflow  out  1  sticky; a completed word was dropped.
- o_sync_err  out  1  sticky; a partial word was discarded by i_sync.

Behaviour:
- Reset (i_rst=1 at a clock edge) has priority over every other input.
  - Clears: FSM=IDLE, internal shift register=0, o_bit_cnt=0, o_par_out=0, o_valid=0, o_busy=0, o_overflow=0, o_sync_err=0.
  - Reset asserted mid-word discards the partial word and any held word.
- Accepted bit: a cycle with i_ser_valid=1. Cycles with i_ser_valid=0 change nothing except output handshake and error clear.
- FSM, IDLE:
  - Accepted bits with i_sync=0 are ignored.
  - An accepted bit with i_sync=1 is stored as bit 0, o_bit_cnt becomes 1, and the FSM moves to ACTIVE.
- FSM, ACTIVE:
  - Each accepted bit shifts in and o_bit_cnt increments.
  - MSB_FIRST=1: shift = {sh[DATA_WIDTH-2:0], i_ser_in}.
  - MSB_FIRST=0: shift = {i_ser_in, sh[DATA_WIDTH-1:1]}.
- Word completion: the accepted bit that brings the count to DATA_WIDTH.
  - o_bit_cnt wraps to 0.
  - The FSM stays in ACTIVE, so the next accepted bit starts the next word with no i_sync needed.
  - Continuous streaming gives back-to-back words with zero bubble.
- Resync: an accepted bit with i_sync=1 while in ACTIVE with o_bit_cnt != 0.
  - The partial word is discarded and o_sync_err is set.
  - The current bit becomes bit 0 and o_bit_cnt becomes 1.
  - i_sync=1 exactly on a word boundary (o_bit_cnt=0) is legal and sets no error.
- Output handshake:
  - Latency: o_valid=1 and o_par_out are updated in the cycle after the edge that sampled the completing bit.
  - Drain: o_valid=1 and i_ready=1 clears o_valid at the next edge, unless a word completes in the same cycle.
  - Simultaneous completion and drain: the new word is loaded and o_valid stays 1 with no gap.
  - Overflow: a word completes while o_valid=1 and i_ready=0. The new word is dropped, o_par_out keeps the old word, and o_overflow is set.
  - o_par_out must not change while o_valid=1 and i_ready=0.
- Sticky flags:
  - i_clr_err=1 clears both o_overflow and o_sync_err at the next edge.
  - If a set event occurs in the same cycle as i_clr_err, the set wins.
- o_busy = (FSM == ACTIVE).

Test Plan:
- Reset, then i_ser_valid=1 continuous, MSB_FIRST=1, bits of 0xA5 MSB first, i_sync=1 on the first bit, i_ready=1 -> o_valid=1 for exactly one cycle, starting the cycle after the 8th bit, with o_par_out=0xA5; o_busy=1 from the 2nd cycle onward.
- Back-to-back 0x3C then 0xC3 with no gap and i_ready=1 -> two single-cycle o_valid pulses 8 cycles apart carrying 0x3C then 0xC3; o_overflow=0.
- i_ready=0, stream 0x11 then 0x22 -> o_par_out stays 0x11 and o_overflow=1 after the 16th bit; then i_ready=1 -> 0x11 accepted and o_valid=0; i_clr_err=1 -> o_overflow=0.
- 0x5A sent with i_ser_valid toggling 1/0 every cycle, plus 3 random bits before i_sync while in IDLE -> pre-sync bits are ignored; o_par_out=0x5A after the 8th valid bit; o_bit_cnt holds during gaps.
- 3 bits of a word, then i_sync=1 with bits of 0x96 -> o_sync_err=1, no o_valid for the partial word, next output 0x96. Repeat with i_rst=1 after 5 bits -> all outputs 0, IDLE, and the next synced word decodes correctly.
- MSB_FIRST=0 build, bits 1,0,0,0,0,0,0,0 -> o_par_out=0x01.
